// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one combinational 32-bit ALU among NREQ requesters.
// Optional per-requester saturating grant counters are built when ALU_ARB_STATS_EN is defined.
module alu_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ),
  parameter int CNTW = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*32-1:0]     req_a,
  input  logic [NREQ*32-1:0]     req_b,
  input  logic [NREQ*3-1:0]      req_ctrl,
  output logic [31:0]            alu_a,
  output logic [31:0]            alu_b,
  output logic [2:0]             alu_ctrl,
  input  logic [31:0]            alu_out,
  input  logic                   alu_zero,
  output logic [NREQ-1:0]        rsp_valid,
  input  logic [NREQ-1:0]        rsp_ready,
  output logic [31:0]            rsp_data,
  output logic                   rsp_zero,
  output logic                   busy,
  output logic [NREQ*CNTW-1:0]   grant_cnt
);

  typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

  state_t          state_q, state_d;
  logic [IDW-1:0]  last_q, owner_q;
  logic [IDW-1:0]  gnt, idx;
  logic            gnt_vld, accept;
  logic [31:0]     op_a_q, op_b_q, rsp_data_q;
  logic [2:0]      op_ctrl_q;
  logic            rsp_zero_q;

  // Rotating priority: search upward starting just after the last grant.
  always_comb begin
    gnt_vld = 1'b0;
    gnt     = '0;
    idx     = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = IDW'((int'(last_q) + k) % NREQ);
      if (!gnt_vld && req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt     = idx;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    case (state_q)
      IDLE: begin
        if (gnt_vld) begin
          accept  = 1'b1;
          state_d = EXEC;
        end
      end
      EXEC: state_d = RESP;
      RESP: begin
        if (rsp_ready[owner_q]) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign req_ready = accept ? (NREQ'(1) << gnt) : '0;
  assign rsp_valid = (state_q == RESP) ? (NREQ'(1) << owner_q) : '0;
  assign busy      = (state_q != IDLE);
  assign alu_a     = op_a_q;
  assign alu_b     = op_b_q;
  assign alu_ctrl  = op_ctrl_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_zero  = rsp_zero_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      last_q     <= IDW'(NREQ - 1);
      owner_q    <= '0;
      op_a_q     <= '0;
      op_b_q     <= '0;
      op_ctrl_q  <= '0;
      rsp_data_q <= '0;
      rsp_zero_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        owner_q   <= gnt;
        last_q    <= gnt;
        op_a_q    <= req_a[32*gnt +: 32];
        op_b_q    <= req_b[32*gnt +: 32];
        op_ctrl_q <= req_ctrl[3*gnt +: 3];
      end
      // ALU is combinational on the op registers; its result is captured at the end of EXEC.
      if (state_q == EXEC) begin
        rsp_data_q <= alu_out;
        rsp_zero_q <= alu_zero;
      end
    end
  end

`ifdef ALU_ARB_STATS_EN
  logic [CNTW-1:0] cnt_q [NREQ];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NREQ; i++) cnt_q[i] <= '0;
    end else if (accept && (cnt_q[gnt] != '1)) begin
      cnt_q[gnt] <= cnt_q[gnt] + 1'b1;
    end
  end

  always_comb begin
    grant_cnt = '0;
    for (int i = 0; i < NREQ; i++) grant_cnt[CNTW*i +: CNTW] = cnt_q[i];
  end
`else
  assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Randomized self-checking bench for alu_arbiter with a behavioural ALU and round-robin model.
module tb_alu_arbiter;
  localparam int NREQ = 4;
  localparam int CNTW = 2;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [NREQ-1:0]      req_valid, req_ready, rsp_valid, rsp_ready;
  logic [NREQ*32-1:0]   req_a, req_b;
  logic [NREQ*3-1:0]    req_ctrl;
  logic [31:0]          alu_a, alu_b, alu_out, rsp_data;
  logic [2:0]           alu_ctrl;
  logic                 alu_zero, rsp_zero, busy;
  logic [NREQ*CNTW-1:0] grant_cnt;

  int n_vec = 0;
  int n_err = 0;
  int last_m;
  int cnt_m [NREQ];

  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(logic [31:0] a, logic [31:0] b, logic [2:0] c);
    case (c)
      3'b000:  return a & b;
      3'b001:  return a | b;
      3'b010:  return a + b;
      3'b110:  return a - b;
      3'b111:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  assign alu_out  = alu_f(alu_a, alu_b, alu_ctrl);
  assign alu_zero = (alu_out == 32'd0);

  alu_arbiter #(.NREQ(NREQ), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_ctrl(req_ctrl),
    .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
    .alu_out(alu_out), .alu_zero(alu_zero),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_zero(rsp_zero),
    .busy(busy), .grant_cnt(grant_cnt)
  );

  function automatic logic [NREQ-1:0] oh(int i);
    return NREQ'(1) << i;
  endfunction

  function automatic int pick(logic [NREQ-1:0] m);
    for (int k = 1; k <= NREQ; k++)
      if (m[(last_m + k) % NREQ]) return (last_m + k) % NREQ;
    return -1;
  endfunction

  function automatic logic [CNTW-1:0] exp_cnt(int i);
`ifdef ALU_ARB_STATS_EN
    int mx = (1 << CNTW) - 1;
    return CNTW'((cnt_m[i] > mx) ? mx : cnt_m[i]);
`else
    return '0;
`endif
  endfunction

  function automatic logic [2:0] rand_ctrl();
    case ($urandom_range(0, 4))
      0: return 3'b000;
      1: return 3'b001;
      2: return 3'b010;
      3: return 3'b110;
      default: return 3'b111;
    endcase
  endfunction

  task automatic model_reset();
    last_m = NREQ - 1;
    for (int i = 0; i < NREQ; i++) cnt_m[i] = 0;
  endtask

  task automatic commit(int g);
    last_m = g;
    cnt_m[g]++;
  endtask

  task automatic set_req(int i, logic [31:0] a, logic [31:0] b, logic [2:0] c);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_ctrl[3*i +: 3] = c;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; req_valid = '0; rsp_ready = '0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    #1;
    n_vec++; if (req_ready !== 4'b0) begin n_err++; $display("FAIL reset_req_ready got=%h exp=0", req_ready); end
    n_vec++; if (rsp_valid !== 4'b0) begin n_err++; $display("FAIL reset_rsp_valid got=%h exp=0", rsp_valid); end
    n_vec++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_vec++; if (alu_a !== 32'd0 || alu_b !== 32'd0) begin n_err++; $display("FAIL reset_alu_ab got=%h/%h exp=0/0", alu_a, alu_b); end
    n_vec++; if (alu_ctrl !== 3'd0) begin n_err++; $display("FAIL reset_alu_ctrl got=%b exp=000", alu_ctrl); end
    n_vec++; if (rsp_data !== 32'd0 || rsp_zero !== 1'b0) begin n_err++; $display("FAIL reset_rsp got=%h/%b exp=0/0", rsp_data, rsp_zero); end
    n_vec++; if (grant_cnt !== '0) begin n_err++; $display("FAIL reset_grant_cnt got=%h exp=0", grant_cnt); end
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_basic();
    int g;
    set_req(0, 32'd5, 32'd3, 3'b010);
    req_valid = 4'b0001;
    #1;
    g = pick(req_valid);
    n_vec++; if (req_ready !== oh(g)) begin n_err++; $display("FAIL basic_req_ready got=%b exp=%b", req_ready, oh(g)); end
    commit(g);
    @(negedge clk);
    req_valid = '0;
    #1;
    n_vec++; if (busy !== 1'b1 || req_ready !== 4'b0) begin n_err++; $display("FAIL basic_exec got busy=%b ready=%b exp 1/0000", busy, req_ready); end
    n_vec++; if (alu_a !== 32'd5 || alu_b !== 32'd3 || alu_ctrl !== 3'b010) begin n_err++; $display("FAIL basic_alu_in got=%h/%h/%b exp=5/3/010", alu_a, alu_b, alu_ctrl); end
    n_vec++; if (rsp_valid !== 4'b0) begin n_err++; $display("FAIL basic_early_rsp got=%b exp=0000", rsp_valid); end
    @(negedge clk);
    #1;
    n_vec++; if (rsp_valid !== 4'b0001) begin n_err++; $display("FAIL basic_rsp_valid got=%b exp=0001", rsp_valid); end
    n_vec++; if (rsp_data !== 32'd8 || rsp_zero !== 1'b0) begin n_err++; $display("FAIL basic_rsp_data got=%h/%b exp=8/0", rsp_data, rsp_zero); end
    rsp_ready = 4'b0001;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    n_vec++; if (busy !== 1'b0 || rsp_valid !== 4'b0) begin n_err++; $display("FAIL basic_back_idle got busy=%b rsp=%b exp 0/0000", busy, rsp_valid); end
  endtask

  task automatic test_zero();
    int g;
    set_req(2, 32'h1234, 32'h1234, 3'b110);
    req_valid = 4'b0100;
    #1;
    g = pick(req_valid);
    n_vec++; if (req_ready !== oh(g)) begin n_err++; $display("FAIL zero_req_ready got=%b exp=%b", req_ready, oh(g)); end
    commit(g);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    n_vec++; if (rsp_valid !== 4'b0100) begin n_err++; $display("FAIL zero_rsp_valid got=%b exp=0100", rsp_valid); end
    n_vec++; if (rsp_data !== 32'd0 || rsp_zero !== 1'b1) begin n_err++; $display("FAIL zero_flag got=%h/%b exp=0/1", rsp_data, rsp_zero); end
    rsp_ready = 4'b0100;
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_round_robin();
    int g;
    logic [31:0] ea, eb, ex;
    logic [2:0] ec;
    do_reset();
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom, $urandom, rand_ctrl());
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    for (int op = 0; op < 2 * NREQ + 1; op++) begin
      #1;
      g = pick(4'hF);
      n_vec++; if (req_ready !== oh(g) || busy !== 1'b0) begin n_err++; $display("FAIL rr_grant op=%0d got=%b busy=%b exp=%b", op, req_ready, busy, oh(g)); end
      ea = req_a[32*g +: 32]; eb = req_b[32*g +: 32]; ec = req_ctrl[3*g +: 3];
      ex = alu_f(ea, eb, ec);
      commit(g);
      @(negedge clk);
      set_req(g, $urandom, $urandom, rand_ctrl());
      #1;
      n_vec++; if (alu_a !== ea || alu_b !== eb || alu_ctrl !== ec) begin n_err++; $display("FAIL rr_alu_in op=%0d got=%h/%h/%b exp=%h/%h/%b", op, alu_a, alu_b, alu_ctrl, ea, eb, ec); end
      @(negedge clk);
      #1;
      n_vec++; if (rsp_valid !== oh(g) || rsp_data !== ex || rsp_zero !== (ex == 0)) begin n_err++; $display("FAIL rr_rsp op=%0d got=%b/%h/%b exp=%b/%h/%b", op, rsp_valid, rsp_data, rsp_zero, oh(g), ex, (ex == 0)); end
      @(negedge clk);
    end
    req_valid = '0;
    rsp_ready = '0;
  endtask

  task automatic test_hold();
    int g;
    logic [31:0] ex;
    g = $urandom_range(0, NREQ - 1);
    set_req(g, $urandom, $urandom, rand_ctrl());
    ex = alu_f(req_a[32*g +: 32], req_b[32*g +: 32], req_ctrl[3*g +: 3]);
    req_valid = oh(g);
    #1;
    n_vec++; if (req_ready !== oh(pick(oh(g)))) begin n_err++; $display("FAIL hold_grant got=%b exp=%b", req_ready, oh(g)); end
    commit(g);
    @(negedge clk);
    req_valid = ~oh(g);
    @(negedge clk);
    for (int c = 0; c < 10; c++) begin
      rsp_ready = NREQ'($urandom) & ~oh(g);
      #1;
      n_vec++; if (rsp_valid !== oh(g) || rsp_data !== ex || req_ready !== 4'b0 || busy !== 1'b1) begin n_err++; $display("FAIL hold_resp c=%0d got=%b/%h/%b exp=%b/%h/0000", c, rsp_valid, rsp_data, req_ready, oh(g), ex); end
      @(negedge clk);
    end
    rsp_ready = oh(g);
    req_valid = '0;
    @(negedge clk);
    rsp_ready = '0;
    #1;
    n_vec++; if (busy !== 1'b0 || rsp_valid !== 4'b0) begin n_err++; $display("FAIL hold_release got busy=%b rsp=%b exp 0/0000", busy, rsp_valid); end
  endtask

  task automatic test_reset_mid();
    int g;
    g = $urandom_range(0, NREQ - 1);
    set_req(g, $urandom, $urandom, rand_ctrl());
    req_valid = oh(g);
    @(negedge clk);
    req_valid = '0;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    #1;
    n_vec++; if (busy !== 1'b0 || rsp_valid !== 4'b0) begin n_err++; $display("FAIL rstmid_state got busy=%b rsp=%b exp 0/0000", busy, rsp_valid); end
    n_vec++; if (alu_a !== 32'd0 || rsp_data !== 32'd0 || grant_cnt !== '0) begin n_err++; $display("FAIL rstmid_regs got=%h/%h/%h exp=0/0/0", alu_a, rsp_data, grant_cnt); end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      #1;
      n_vec++; if (rsp_valid !== 4'b0) begin n_err++; $display("FAIL rstmid_no_rsp c=%0d got=%b exp=0000", c, rsp_valid); end
    end
    set_req(0, 32'd7, 32'd7, 3'b110);
    req_valid = 4'b1001;
    #1;
    g = pick(req_valid);
    n_vec++; if (req_ready !== oh(g)) begin n_err++; $display("FAIL rstmid_last got=%b exp=%b", req_ready, oh(g)); end
    commit(g);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    rsp_ready = oh(g);
    @(negedge clk);
    rsp_ready = '0;
  endtask

  task automatic test_random();
    int g, d;
    logic [NREQ-1:0] m;
    logic [31:0] ea, eb, ex;
    logic [2:0] ec;
    for (int op = 0; op < 40; op++) begin
      for (int i = 0; i < NREQ; i++) set_req(i, (op % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom, (op % 4 == 0) ? 32'($urandom_range(0, 3)) : $urandom, rand_ctrl());
      m = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      req_valid = m;
      #1;
      g = pick(m);
      n_vec++; if (req_ready !== oh(g) || busy !== 1'b0) begin n_err++; $display("FAIL rnd_grant op=%0d got=%b busy=%b exp=%b", op, req_ready, busy, oh(g)); end
      ea = req_a[32*g +: 32]; eb = req_b[32*g +: 32]; ec = req_ctrl[3*g +: 3];
      ex = alu_f(ea, eb, ec);
      commit(g);
      @(negedge clk);
      req_valid = '0;
      #1;
      n_vec++; if (alu_a !== ea || alu_b !== eb || alu_ctrl !== ec) begin n_err++; $display("FAIL rnd_alu_in op=%0d got=%h/%h/%b exp=%h/%h/%b", op, alu_a, alu_b, alu_ctrl, ea, eb, ec); end
      @(negedge clk);
      d = $urandom_range(0, 3);
      for (int c = 0; c < d; c++) begin
        rsp_ready = NREQ'($urandom) & ~oh(g);
        @(negedge clk);
      end
      rsp_ready = oh(g) | NREQ'($urandom);
      #1;
      n_vec++; if (rsp_valid !== oh(g) || rsp_data !== ex || rsp_zero !== (ex == 0)) begin n_err++; $display("FAIL rnd_rsp op=%0d got=%b/%h/%b exp=%b/%h/%b", op, rsp_valid, rsp_data, rsp_zero, oh(g), ex, (ex == 0)); end
      @(negedge clk);
      rsp_ready = '0;
    end
  endtask

  task automatic test_stats();
    int g;
    do_reset();
    set_req(1, 32'd1, 32'd2, 3'b010);
    rsp_ready = 4'b0010;
    for (int n = 0; n < 5; n++) begin
      req_valid = 4'b0010;
      #1;
      g = pick(req_valid);
      n_vec++; if (req_ready !== oh(g)) begin n_err++; $display("FAIL stats_grant n=%0d got=%b exp=%b", n, req_ready, oh(g)); end
      commit(g);
      @(negedge clk);
      req_valid = '0;
      #1;
      n_vec++; if (grant_cnt[CNTW*1 +: CNTW] !== exp_cnt(1) || grant_cnt[0 +: CNTW] !== exp_cnt(0)) begin n_err++; $display("FAIL stats_cnt n=%0d got=%h exp1=%0d exp0=%0d", n, grant_cnt, exp_cnt(1), exp_cnt(0)); end
      @(negedge clk);
      @(negedge clk);
    end
    rsp_ready = '0;
  endtask

  initial begin
    rst_n = 1'b0;
    req_valid = '0; rsp_ready = '0;
    req_a = '0; req_b = '0; req_ctrl = '0;
    model_reset();
    test_reset();
    test_basic();
    test_zero();
    test_round_robin();
    test_hold();
    test_reset_mid();
    test_random();
    test_stats();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
